// File: rtl/consume_scheduler_if.sv
// Issue handshake between consume_scheduler (master) and the tile requesters / consumer (slave).
interface consume_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0] req;
    logic               consumer_ready;
    logic [NUM_REQ-1:0] grant;
    logic               consume_start;

    modport master (
        input  req,
        input  consumer_ready,
        output grant,
        output consume_start
    );

    modport slave (
        output req,
        output consumer_ready,
        input  grant,
        input  consume_start
    );
endinterface

// File: rtl/consume_scheduler.sv
// Round-robin tile issue scheduler: issues tiles to a consumer until a frame's columns are covered.
// Optional stall timeout is compiled in when SCHED_TIMEOUT_EN is defined.
module consume_scheduler #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FRAME_COLS = 64,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [15:0]                tile_columns,
    consume_scheduler_if.master        bus,
    output logic                       busy,
    output logic                       frame_done,
    output logic [15:0]                tiles_issued,
    output logic                       error
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned ACC_W  = 17;
    localparam int unsigned TILE_W = 16;
    localparam int unsigned CNT_W  = 8;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT == 0 || TIMEOUT > 255 ||
        FRAME_COLS == 0 || FRAME_COLS > 65536) begin : g_bad_cfg
        $error("consume_scheduler: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    last_win;
    logic [TILE_W-1:0]   tile_cols_q;
    logic [ACC_W-1:0]    acc;

`ifdef SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0]    stall_cnt;
`endif

    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    win_idx;
    logic                win_found;
    logic [NUM_REQ-1:0]  win_oh;
    logic                issue_c;

    // Round-robin search starting just above the last winner, wrapping at NUM_REQ-1.
    always_comb begin
        cand      = last_win;
        win_idx   = last_win;
        win_found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + IDX_W'(1);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    // Issue is decided in the ARB cycle itself so the consumer sees it without an extra cycle.
    assign issue_c           = (state == S_ARB) && bus.consumer_ready && win_found;
    assign bus.consume_start = issue_c;
    assign bus.grant         = issue_c ? win_oh : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            tiles_issued <= '0;
            error        <= 1'b0;
            acc          <= '0;
            tile_cols_q  <= '0;
            last_win     <= IDX_W'(NUM_REQ - 1);
`ifdef SCHED_TIMEOUT_EN
            stall_cnt    <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start && !error) begin
                        if (tile_columns == '0) begin
                            error <= 1'b1;
                        end else begin
                            tile_cols_q  <= tile_columns;
                            acc          <= '0;
                            tiles_issued <= '0;
                            state        <= S_ARB;
                            busy         <= 1'b1;
                        end
                    end
                end

                S_ARB: begin
                    if (issue_c) begin
                        last_win     <= win_idx;
                        tiles_issued <= tiles_issued + 16'd1;
                        acc          <= acc + ACC_W'(tile_cols_q);
                        state        <= S_GAP;
`ifdef SCHED_TIMEOUT_EN
                        stall_cnt    <= '0;
`endif
                    end
`ifdef SCHED_TIMEOUT_EN
                    // A pending request the consumer never accepts aborts the frame.
                    else if (win_found) begin
                        if (stall_cnt == STALL_LIM) begin
                            error     <= 1'b1;
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            stall_cnt <= '0;
                        end else begin
                            stall_cnt <= stall_cnt + CNT_W'(1);
                        end
                    end
`endif
                end

                S_GAP: begin
                    if (acc >= ACC_W'(FRAME_COLS)) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                    end else begin
                        state <= S_ARB;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_consume_scheduler.sv
// Scoreboard bench for consume_scheduler: frame-level reference model feeds queues, a monitor checks the DUT.
module tb_consume_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned FC = 64;
    localparam int unsigned TO = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] tile_columns = '0;
    logic        busy;
    logic        frame_done;
    logic [15:0] tiles_issued;
    logic        error;

    consume_scheduler_if #(.NUM_REQ(N)) bus ();

    consume_scheduler #(
        .NUM_REQ   (N),
        .FRAME_COLS(FC),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .tile_columns(tile_columns),
        .bus         (bus),
        .busy        (busy),
        .frame_done  (frame_done),
        .tiles_issued(tiles_issued),
        .error       (error)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [N-1:0] q_grant[$];
    int           q_tiles[$];
    int           m_issues = 0;
    int           consumed_count = 0;
    int           grant_sum = 0;

    // Reference model: frame as "columns still to cover"; issue allowed every other cycle.
    initial begin : model
        bit           m_ok, m_gap, m_done, m_err, ex;
        int           m_left, m_T, m_tiles, m_last, m_stall, w;
        logic [N-1:0] r, one;
        m_ok = 0; m_gap = 0; m_done = 0; m_err = 0;
        m_left = 0; m_T = 0; m_tiles = 0; m_last = N - 1; m_stall = 0;
        one = 1;
        forever begin
            @(negedge clk);
            r  = bus.req;
            ex = m_ok && bus.consumer_ready && (r != '0);
            w  = -1;
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_last + k) % N;
                if (w < 0 && ((r >> idx) & one) != '0) w = idx;
            end
            if (ex) begin
                q_grant.push_back(one << w);
                m_issues++;
            end
            if (m_done) q_tiles.push_back(m_tiles);
            chk("busy", busy, m_ok || m_gap || m_done);
            chk("error", error, m_err);
            chk("tiles_issued", tiles_issued, m_tiles);

            if (rst) begin
                m_ok = 0; m_gap = 0; m_done = 0; m_err = 0;
                m_tiles = 0; m_last = N - 1; m_stall = 0;
            end else if (m_done) begin
                m_done = 0;
            end else if (m_gap) begin
                m_gap = 0;
                if (m_left <= 0) m_done = 1;
                else m_ok = 1;
            end else if (m_ok) begin
                if (ex) begin
                    m_tiles++;
                    m_left -= m_T;
                    m_last  = w;
                    m_ok    = 0;
                    m_gap   = 1;
                    m_stall = 0;
                end
`ifdef SCHED_TIMEOUT_EN
                else if (r != '0) begin
                    m_stall++;
                    if (m_stall >= TO) begin
                        m_err   = 1;
                        m_ok    = 0;
                        m_stall = 0;
                    end
                end
`endif
            end else if (start && !m_err) begin
                if (tile_columns == 16'd0) begin
                    m_err = 1;
                end else begin
                    m_T     = int'(tile_columns);
                    m_left  = FC;
                    m_tiles = 0;
                    m_ok    = 1;
                end
            end
        end
    end

    // Monitor: pops expected grants on issue and expected tile counts on frame end.
    initial begin : monitor
        bit           exp_issue, exp_fd;
        logic [N-1:0] g;
        int           t;
        forever begin
            @(negedge clk);
            #1;
            if (bus.consume_start === 1'b1) consumed_count++;
            grant_sum += $countones(bus.grant);
            exp_issue = (q_grant.size() != 0);
            chk("consume_start", bus.consume_start, exp_issue);
            if (exp_issue) begin
                g = q_grant.pop_front();
                chk("grant", bus.grant, g);
            end else begin
                chk("grant_idle", bus.grant, '0);
            end
            exp_fd = (q_tiles.size() != 0);
            chk("frame_done", frame_done, exp_fd);
            if (exp_fd) begin
                t = q_tiles.pop_front();
                chk("frame_tiles", tiles_issued, t);
            end
        end
    end

    task automatic pulse_start(input logic [15:0] tc);
        @(posedge clk); #1;
        start        = 1'b1;
        tile_columns = tc;
        @(posedge clk); #1;
        start        = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen, output logic [15:0] t,
                             output logic [15:0] gseq);
        seen = 0; t = '0; gseq = '0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.consume_start === 1'b1) gseq = {gseq[11:0], bus.grant};
            if (frame_done === 1'b1) begin
                seen = 1;
                t    = tiles_issued;
            end
        end
    endtask

    initial begin : stim
        bit          seen;
        logic [15:0] t, gseq;
        int          issues;
        bus.req            = '0;
        bus.consumer_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Four equal tiles, all requesters ready.
        bus.req = 4'b1111; bus.consumer_ready = 1'b1;
        pulse_start(16'd16);
        wait_done(40, seen, t, gseq);
        chk("f1_done_seen", seen, 1'b1);
        chk("f1_tiles", t, 16'd4);
        chk("f1_grant_seq", gseq, 16'h1248);

        // Overshooting last tile, sparse requesters.
        bus.req = 4'b0101;
        pulse_start(16'd24);
        wait_done(40, seen, t, gseq);
        chk("f2_done_seen", seen, 1'b1);
        chk("f2_tiles", t, 16'd3);
        chk("f2_grant_seq", gseq, 16'h0141);

        // Zero-width tile sets sticky error; a later good start is ignored.
        pulse_start(16'd0);
        @(negedge clk);
        chk("cfg_err_error", error, 1'b1);
        chk("cfg_err_busy", busy, 1'b0);
        bus.req = 4'b1111;
        pulse_start(16'd16);
        repeat (3) @(negedge clk);
        chk("cfg_err_ignored_busy", busy, 1'b0);
        chk("cfg_err_sticky", error, 1'b1);
        do_reset();

        // Reset in the middle of a frame.
        pulse_start(16'd16);
        issues = 0;
        for (int i = 0; i < 20 && issues < 2; i++) begin
            @(negedge clk);
            if (bus.consume_start === 1'b1) issues++;
        end
        chk("mid_issues", issues, 2);
        do_reset();
        @(negedge clk);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_tiles", tiles_issued, 16'd0);
        chk("mid_rst_done", frame_done, 1'b0);

        // Stalled consumer with one requester pending.
        bus.req = 4'b0001; bus.consumer_ready = 1'b0;
        pulse_start(16'd16);
        repeat (300) @(negedge clk);
`ifdef SCHED_TIMEOUT_EN
        chk("stall_error", error, 1'b1);
        chk("stall_idle", busy, 1'b0);
`else
        chk("stall_busy", busy, 1'b1);
        chk("stall_no_error", error, 1'b0);
`endif
        do_reset();

        // Randomized traffic; occasional resets recover from sticky errors.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst                = ($urandom_range(0, 399) == 0);
            bus.req            = N'($urandom);
            bus.consumer_ready = ($urandom_range(0, 3) != 0);
            start              = ($urandom_range(0, 5) == 0);
            tile_columns       = ($urandom_range(0, 47) == 0) ? 16'd0 : 16'($urandom_range(1, 70));
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; bus.req = '0;
        repeat (4) @(negedge clk);
        #2;
        chk("consumed_vs_grants", consumed_count, grant_sum);
        chk("consumed_vs_model", consumed_count, m_issues);
        chk("grant_q_drained", q_grant.size(), 0);
        chk("tiles_q_drained", q_tiles.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/consume_scheduler.md
CONSUME_SCHEDULER -- requirements
Module: consume_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of tile requesters (2..8).
REQ-002 The block SHALL have parameter FRAME_COLS, default 64, giving the frame width in columns.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, giving the stall limit in cycles (8-bit counter).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1, a one-cycle pulse that begins a frame.
REQ-007 The block SHALL have port tile_columns, input, 16, the columns per tile, sampled on start.
REQ-008 The block SHALL have port req, input, NUM_REQ, one bit per requester that holds a tile ready.
REQ-009 The block SHALL have port consumer_ready, input, 1, driven by the consumer's ready_to_consume.
REQ-010 The block SHALL have port grant, output, NUM_REQ, a one-hot grant pulse.
REQ-011 The block SHALL have port consume_start, output, 1, the issue pulse to the consumer.
REQ-012 The block SHALL have port busy, output, 1, high when the state is not IDLE.
REQ-013 The block SHALL have port frame_done, output, 1, a one-cycle pulse at frame end.
REQ-014 The block SHALL have port tiles_issued, output, 16, the count of tiles issued in the current frame.
REQ-015 The block SHALL have port error, output, 1, a sticky flag for bad configuration or timeout.

Function
REQ-016 The state machine SHALL have states IDLE, ARB, GAP and DONE.
REQ-017 In IDLE, start with tile_columns != 0 SHALL latch tile_columns, clear the 17-bit column accumulator and tiles_issued, and go to ARB the next cycle.
REQ-018 In IDLE, start with tile_columns == 0 SHALL set error and keep the state IDLE.
REQ-019 In IDLE, start with error set SHALL have no effect.
REQ-020 In ARB, when consumer_ready=1 and req!=0, the block SHALL, in that same cycle and combinationally from registered state, assert consume_start=1 and grant=one-hot winner.
REQ-021 On that ARB cycle the block SHALL register the winner, increment tiles_issued, add the latched tile_columns to the accumulator, and go to GAP.
REQ-022 The winner SHALL be chosen round-robin: first set req bit at index above the last winner, wrapping; last winner resets to NUM_REQ-1, so requester 0 wins first.
REQ-023 In ARB with consumer_ready=0 or req=0, the block SHALL assert no grant and no consume_start.
REQ-024 GAP SHALL last exactly one cycle with no issue, then go to DONE if accumulator >= FRAME_COLS, else to ARB; back-to-back issues are therefore two cycles apart.
REQ-025 A partial last tile (accumulator overshooting FRAME_COLS) SHALL count as a full tile.
REQ-026 DONE SHALL pulse frame_done for one cycle and then go to IDLE; tiles_issued SHALL hold until the next accepted start.
REQ-027 start while not in IDLE SHALL be ignored.
REQ-028 A req bit dropping before it is granted SHALL simply be skipped by the arbiter; no grant is owed to it.

Reset
REQ-029 With rst=1 at a clock edge, the block SHALL go to IDLE and clear grant, consume_start, busy, frame_done, tiles_issued, error, the accumulator and the stall counter, and reset last winner to NUM_REQ-1.
REQ-030 Reset SHALL take priority over all other inputs, including mid-frame and during an issue cycle.
REQ-031 Reset SHALL be the only way to clear error.

Configuration
REQ-032 With macro SCHED_TIMEOUT_EN defined, the stall counter SHALL increment on each ARB cycle where req!=0 and consumer_ready=0, and clear on any issue or on leaving ARB.
REQ-033 With SCHED_TIMEOUT_EN defined, when the stall counter reaches TIMEOUT the block SHALL set error and go to IDLE without pulsing frame_done.
REQ-034 Without SCHED_TIMEOUT_EN, the stall counter SHALL not exist and ARB SHALL wait indefinitely.

Verification
REQ-035 With tile_columns=16, req=4'b1111 and consumer_ready=1 constant, start SHALL produce 4 issues granting 0001, 0010, 0100, 1000, two cycles apart, then frame_done, with tiles_issued=4.
REQ-036 With tile_columns=24 and req=4'b0101, there SHALL be 3 issues granting 0001, 0100, 0001, then frame_done, with tiles_issued=3.
REQ-037 start with tile_columns=0 SHALL set error=1 and keep busy=0; a later start with tile_columns=16 SHALL be ignored until rst.
REQ-038 Asserting rst after 2 of 4 issues SHALL on the next cycle give busy=0, tiles_issued=0, and no frame_done.
REQ-039 With SCHED_TIMEOUT_EN defined, req=4'b0001 and consumer_ready=0 held, error SHALL rise after 255 ARB cycles, followed by IDLE; without the macro, busy SHALL stay 1.
REQ-040 With a consumer_dpm model driven by consume_start, its consumed_count SHALL equal the total consume_start pulses and the sum of all grants.
